block_dispatcher: RTL and testbench
===================================

# block_dispatcher

Kernel-level block scheduler between the host config interface and the array of compute cores. It latches a `kernel_config_t` on `start` and issues block IDs `0 .. num_blocks-1` to free cores in round-robin order over a valid/ready handshake. It tracks per-core busy state from completion pulses and raises `kernel_done` once every issued block has retired.

## Interface
Parameters:
- `NUM_CORES`, 32: number of cores; ≥2, power of two not required.
- `CORE_ID_W`, `$clog2(NUM_CORES)`: derived localparam; core index width.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: kernel launch; sampled only in IDLE.
- `cfg`, in, `kernel_config_t`: kernel parameters; sampled with `start`.
- `busy`, out, 1: high in any state other than IDLE.
- `kernel_done`, out, 1: one-cycle pulse when the kernel completes.
- `disp_valid`, out, 1: dispatch request pending.
- `disp_ready`, in, 1: target core accepts dispatch.
- `disp_core`, out, `CORE_ID_W`: target core index.
- `disp_block_id`, out, `data_t`: block index being issued.
- `disp_num_warps`, out, `data_t`: latched `num_warps_per_block`.
- `disp_base_instr_addr`, out, `instr_mem_addr_t`: latched base instruction address.
- `disp_base_data_addr`, out, `data_mem_addr_t`: latched base data address.
- `core_done`, in, `NUM_CORES`: per-core one-cycle block-completion pulse.

## Operation
- States: IDLE, DISPATCH, DRAIN.
- IDLE + `start`:
  - Latch `cfg`.
  - Clear `issued_cnt`, `done_cnt` and `rr_ptr`.
  - If `cfg.num_blocks == 0`: pulse `kernel_done` next cycle and stay IDLE.
  - Otherwise go to DISPATCH.
- `start` outside IDLE is ignored. `cfg` changes outside the `start` cycle have no effect.
- `core_busy[NUM_CORES]`:
  - Set on handshake (`disp_valid && disp_ready`) for `disp_core`.
  - Cleared by `core_done[k]`.
  - `core_done` on a non-busy core is ignored and not counted.
- Selection:
  - Free mask = `~core_busy`.
  - Grant the lowest free index ≥ `rr_ptr`; if none, wrap to the lowest free index overall.
  - When no core is free, `disp_valid` stays low.
- DISPATCH, no request pending: when a free core exists and `issued_cnt < num_blocks`, register `disp_core`, set `disp_block_id = issued_cnt`, and assert `disp_valid`.
- `disp_valid` held, outputs stable until handshake. Cores freeing while a request is pending do not change `disp_core`.
- On handshake:
  - `issued_cnt++`.
  - `rr_ptr = (disp_core + 1) mod NUM_CORES`.
  - `disp_valid` low the next cycle.
  - If `issued_cnt + 1 == num_blocks`, go to DRAIN.
- DRAIN: when `done_cnt == num_blocks`, pulse `kernel_done` and return to IDLE.
- `done_cnt` increments by popcount of valid `core_done` bits each cycle, so multiple simultaneous completions are supported.
- Counters are 32-bit. `num_blocks` up to 2^32−1; no wrap is possible since `issued_cnt` stops at `num_blocks`.

## Timing
- Reset values (asynchronous, immediate): state IDLE; `busy` 0, `kernel_done` 0, `disp_valid` 0; `disp_core` 0, `disp_block_id` 0, `disp_num_warps` 0; both base addresses 0; `core_busy` all 0; counters 0; `rr_ptr` 0.
- `start` to first `disp_valid`: 2 cycles (latch, then register selection).
- A core freed by `core_done` at cycle t is selectable at t+1, so `disp_valid` can assert at t+2.
- Peak throughput: one dispatch per 2 cycles (handshake cycle, then re-select cycle).
- Same-cycle `core_done[k]` and handshake to core j≠k: both take effect.
- Last `core_done` at cycle t in DRAIN: `kernel_done` high at t+1 and `busy` low at t+2.
- Reset mid-kernel: everything aborts, and no `kernel_done` is produced.

## Structure
- `common_pkg` gains:
  - `dispatch_state_e` (IDLE, DISPATCH, DRAIN).
  - `dispatch_req_t`, a packed struct of block_id, num_warps and the two base addresses, used for the `disp_*` payload.
- One sub-module, `rr_arbiter #(NUM_CORES)`:
  - Combinational round-robin priority encoder.
  - Inputs: request mask, pointer.
  - Outputs: `grant_valid`, binary `grant_idx`.
  - It supersedes the plain one-hot-to-binary helper.
- Counters, state FSM and busy vector live in `block_dispatcher`.

## Test plan
- NUM_CORES=4, num_blocks=6, `disp_ready` tied 1, no `core_done`:
  - Blocks 0–3 go to cores 0,1,2,3.
  - `disp_valid` then stays low.
  - Pulse `core_done[2]`: block 4 goes to core 2.
- `num_blocks=0` start: `kernel_done` pulses exactly once, 1 cycle after `start`; `disp_valid` never asserts.
- `rr_ptr`=3 with cores 0 and 3 busy, then `core_done[3]` and `core_done[0]` in the same cycle: next grant is core 3 (wrap order 3,0), and `done_cnt` increments by 2.
- `disp_ready` held low for 5 cycles while another core frees: `disp_core` and `disp_block_id` stay stable; one dispatch occurs on the ready cycle.
- num_blocks=3 completed:
  - Spurious `core_done` on an idle core is not counted.
  - `kernel_done` follows the third real completion by 1 cycle.
  - A `start` sent during DRAIN is ignored.
- Drop `rst_n` mid-DISPATCH with `disp_valid` high: outputs zero immediately. After release, a new kernel starts from block 0 and core 0.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types for the kernel dispatch path: config payload, dispatch payload, FSM states.
package common_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned INSTR_ADDR_W = 16;
  localparam int unsigned DATA_ADDR_W  = 16;

  typedef logic [DATA_W-1:0]       data_t;
  typedef logic [INSTR_ADDR_W-1:0] instr_mem_addr_t;
  typedef logic [DATA_ADDR_W-1:0]  data_mem_addr_t;

  typedef struct packed {
    instr_mem_addr_t base_instr_addr;
    data_mem_addr_t  base_data_addr;
    data_t           num_blocks;
    data_t           num_warps_per_block;
  } kernel_config_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } dispatch_state_e;

  typedef struct packed {
    data_t           block_id;
    data_t           num_warps;
    instr_mem_addr_t base_instr_addr;
    data_mem_addr_t  base_data_addr;
  } dispatch_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: lowest request at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter  int unsigned NUM_CORES = 32,
  localparam int unsigned CORE_ID_W = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [CORE_ID_W-1:0] ptr,
  output logic                 grant_valid,
  output logic [CORE_ID_W-1:0] grant_idx
);

  logic                 w_hi_found;
  logic                 w_lo_found;
  logic [CORE_ID_W-1:0] w_hi_idx;
  logic [CORE_ID_W-1:0] w_lo_idx;

  // Descending scan so the last hit is the lowest index in each window.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = CORE_ID_W'(i);
        if (CORE_ID_W'(i) >= ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = CORE_ID_W'(i);
        end
      end
    end
  end

  assign grant_valid = w_lo_found;
  assign grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/block_dispatcher.sv
// Kernel block scheduler: issues block IDs round-robin to free cores and reports kernel completion.
module block_dispatcher
  import common_pkg::*;
#(
  parameter  int unsigned NUM_CORES = 32,
  localparam int unsigned CORE_ID_W = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  kernel_config_t       cfg,
  output logic                 busy,
  output logic                 kernel_done,
  output logic                 disp_valid,
  input  logic                 disp_ready,
  output logic [CORE_ID_W-1:0] disp_core,
  output data_t                disp_block_id,
  output data_t                disp_num_warps,
  output instr_mem_addr_t      disp_base_instr_addr,
  output data_mem_addr_t       disp_base_data_addr,
  input  logic [NUM_CORES-1:0] core_done
);

  dispatch_state_e      r_state;
  data_t                r_num_blocks;
  data_t                r_issued_cnt;
  data_t                r_done_cnt;
  logic [CORE_ID_W-1:0] r_rr_ptr;
  logic [CORE_ID_W-1:0] r_disp_core;
  logic [NUM_CORES-1:0] r_core_busy;
  dispatch_req_t        r_req;
  logic                 r_busy;
  logic                 r_kernel_done;
  logic                 r_disp_valid;

  logic                 w_grant_valid;
  logic [CORE_ID_W-1:0] w_grant_idx;
  logic                 w_handshake;
  logic [NUM_CORES-1:0] w_done_valid;
  logic [NUM_CORES-1:0] w_set_mask;
  data_t                w_done_next;
  logic [CORE_ID_W-1:0] w_rr_next;
  logic                 w_launch;

  assign w_handshake  = r_disp_valid & disp_ready;
  assign w_done_valid = core_done & r_core_busy;
  assign w_set_mask   = w_handshake ? (NUM_CORES'(1) << r_disp_core) : '0;
  assign w_done_next  = r_done_cnt + DATA_W'($countones(w_done_valid));
  assign w_rr_next    = (r_disp_core == CORE_ID_W'(NUM_CORES - 1)) ? '0
                                                                    : r_disp_core + CORE_ID_W'(1);
  assign w_launch     = (r_state == IDLE) && start;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .req         (~r_core_busy),
    .ptr         (r_rr_ptr),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // Per-core busy tracking and completion counting; spurious completions are masked out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_busy <= '0;
      r_done_cnt  <= '0;
    end else begin
      r_core_busy <= (r_core_busy & ~w_done_valid) | w_set_mask;
      r_done_cnt  <= w_launch ? '0 : w_done_next;
    end
  end

  // Kernel FSM with registered dispatch request and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_num_blocks  <= '0;
      r_issued_cnt  <= '0;
      r_rr_ptr      <= '0;
      r_disp_core   <= '0;
      r_req         <= '0;
      r_busy        <= 1'b0;
      r_kernel_done <= 1'b0;
      r_disp_valid  <= 1'b0;
    end else begin
      r_kernel_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num_blocks          <= cfg.num_blocks;
            r_issued_cnt          <= '0;
            r_rr_ptr              <= '0;
            r_req.num_warps       <= cfg.num_warps_per_block;
            r_req.base_instr_addr <= cfg.base_instr_addr;
            r_req.base_data_addr  <= cfg.base_data_addr;
            if (cfg.num_blocks == '0) begin
              r_kernel_done <= 1'b1;
            end else begin
              r_state <= DISPATCH;
              r_busy  <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          if (w_handshake) begin
            r_disp_valid <= 1'b0;
            r_issued_cnt <= r_issued_cnt + DATA_W'(1);
            r_rr_ptr     <= w_rr_next;
            if (r_issued_cnt + DATA_W'(1) == r_num_blocks) begin
              r_state <= DRAIN;
            end
          end else if (!r_disp_valid && w_grant_valid && (r_issued_cnt < r_num_blocks)) begin
            r_disp_valid   <= 1'b1;
            r_disp_core    <= w_grant_idx;
            r_req.block_id <= r_issued_cnt;
          end
        end
        DRAIN: begin
          if (r_done_cnt == r_num_blocks) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_done_next == r_num_blocks) begin
            r_kernel_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy                 = r_busy;
  assign kernel_done          = r_kernel_done;
  assign disp_valid           = r_disp_valid;
  assign disp_core            = r_disp_core;
  assign disp_block_id        = r_req.block_id;
  assign disp_num_warps       = r_req.num_warps;
  assign disp_base_instr_addr = r_req.base_instr_addr;
  assign disp_base_data_addr  = r_req.base_data_addr;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with four cores.
module tb_block_dispatcher;
  import common_pkg::*;

  localparam int unsigned NC = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  kernel_config_t  cfg;
  logic            busy;
  logic            kernel_done;
  logic            disp_valid;
  logic            disp_ready = 1'b0;
  logic [1:0]      disp_core;
  data_t           disp_block_id;
  data_t           disp_num_warps;
  instr_mem_addr_t disp_base_instr_addr;
  data_mem_addr_t  disp_base_data_addr;
  logic [NC-1:0]   core_done = '0;

  int n_cmp = 0;
  int n_err = 0;

  block_dispatcher #(.NUM_CORES(NC)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .cfg                  (cfg),
    .busy                 (busy),
    .kernel_done          (kernel_done),
    .disp_valid           (disp_valid),
    .disp_ready           (disp_ready),
    .disp_core            (disp_core),
    .disp_block_id        (disp_block_id),
    .disp_num_warps       (disp_num_warps),
    .disp_base_instr_addr (disp_base_instr_addr),
    .disp_base_data_addr  (disp_base_data_addr),
    .core_done            (core_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] nb);
    cfg.num_blocks = nb;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expects a pending request now, lets it handshake, then steps through the re-select cycle.
  task automatic expect_dispatch(input int core, input int blk);
    chk("disp_valid", 32'(disp_valid), 32'd1);
    chk("disp_core", 32'(disp_core), 32'(core));
    chk("disp_block_id", disp_block_id, 32'(blk));
    step();
    chk("valid_after_hs", 32'(disp_valid), 32'd0);
    step();
  endtask

  task automatic pulse_done(input logic [NC-1:0] m);
    core_done = m;
    step();
    core_done = '0;
  endtask

  initial begin
    cfg = '0;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_kdone", 32'(kernel_done), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_core", 32'(disp_core), 32'd0);
    chk("rst_blk", disp_block_id, 32'd0);
    chk("rst_warps", disp_num_warps, 32'd0);
    chk("rst_iaddr", 32'(disp_base_instr_addr), 32'd0);
    chk("rst_daddr", 32'(disp_base_data_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Six blocks over four cores, ready tied high
    disp_ready = 1'b1;
    cfg.base_instr_addr     = 16'h1000;
    cfg.base_data_addr      = 16'h2000;
    cfg.num_warps_per_block = 32'd4;
    launch(32'd6);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_latch", 32'(disp_valid), 32'd0);
    cfg.num_warps_per_block = 32'd9;
    cfg.base_instr_addr     = 16'hdead;
    step();
    chk("t1_warps", disp_num_warps, 32'd4);
    chk("t1_iaddr", 32'(disp_base_instr_addr), 32'h1000);
    chk("t1_daddr", 32'(disp_base_data_addr), 32'h2000);
    for (int b = 0; b < 4; b++) expect_dispatch(b, b);
    for (int k = 0; k < 3; k++) begin
      chk("t1_all_busy_idle", 32'(disp_valid), 32'd0);
      step();
    end
    pulse_done(4'b0100);
    chk("t1_free_t1", 32'(disp_valid), 32'd0);
    step();
    expect_dispatch(2, 4);
    chk("t1_warps_kept", disp_num_warps, 32'd4);

    // Ready held low while another core frees
    disp_ready = 1'b0;
    pulse_done(4'b0001);
    chk("t4_wait", 32'(disp_valid), 32'd0);
    step();
    chk("t4_valid", 32'(disp_valid), 32'd1);
    chk("t4_core", 32'(disp_core), 32'd0);
    chk("t4_blk", disp_block_id, 32'd5);
    for (int k = 0; k < 5; k++) begin
      core_done = (k == 1) ? 4'b0010 : 4'b0000;
      step();
      chk("t4_hold_valid", 32'(disp_valid), 32'd1);
      chk("t4_hold_core", 32'(disp_core), 32'd0);
      chk("t4_hold_blk", disp_block_id, 32'd5);
    end
    core_done = '0;
    disp_ready = 1'b1;
    step();
    chk("t4_one_dispatch", 32'(disp_valid), 32'd0);
    step();
    chk("t4_drain_novalid", 32'(disp_valid), 32'd0);
    pulse_done(4'b1101);
    chk("t1_kdone", 32'(kernel_done), 32'd1);
    chk("t1_busy_hold", 32'(busy), 32'd1);
    step();
    chk("t1_kdone_pulse", 32'(kernel_done), 32'd0);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // Zero-block kernel
    launch(32'd0);
    chk("t2_kdone", 32'(kernel_done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_valid", 32'(disp_valid), 32'd0);
    step();
    chk("t2_kdone_once", 32'(kernel_done), 32'd0);
    chk("t2_valid2", 32'(disp_valid), 32'd0);
    step();
    chk("t2_kdone_none", 32'(kernel_done), 32'd0);

    // Wrap order with simultaneous completions at rr_ptr=3
    launch(32'd8);
    step();
    for (int b = 0; b < 4; b++) expect_dispatch(b, b);
    pulse_done(4'b0110);
    chk("t3_wait1", 32'(disp_valid), 32'd0);
    step();
    expect_dispatch(1, 4);
    expect_dispatch(2, 5);
    pulse_done(4'b1001);
    chk("t3_wait2", 32'(disp_valid), 32'd0);
    step();
    expect_dispatch(3, 6);
    expect_dispatch(0, 7);
    pulse_done(4'b1111);
    chk("t3_kdone_cnt", 32'(kernel_done), 32'd1);
    step();
    chk("t3_kdone_pulse", 32'(kernel_done), 32'd0);
    chk("t3_busy_low", 32'(busy), 32'd0);

    // Three blocks: spurious completion and start during DRAIN
    launch(32'd3);
    step();
    expect_dispatch(0, 0);
    expect_dispatch(1, 1);
    expect_dispatch(2, 2);
    pulse_done(4'b1000);
    chk("t5_spurious", 32'(kernel_done), 32'd0);
    cfg.num_blocks = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_start_ignored", 32'(kernel_done), 32'd0);
    chk("t5_busy_drain", 32'(busy), 32'd1);
    pulse_done(4'b0001);
    chk("t5_done1", 32'(kernel_done), 32'd0);
    pulse_done(4'b0010);
    chk("t5_done2", 32'(kernel_done), 32'd0);
    pulse_done(4'b0100);
    chk("t5_done3", 32'(kernel_done), 32'd1);
    step();
    chk("t5_kdone_pulse", 32'(kernel_done), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    step();
    chk("t5_no_late_kdone", 32'(kernel_done), 32'd0);
    chk("t5_no_valid", 32'(disp_valid), 32'd0);

    // Reset mid-DISPATCH with a request pending
    cfg.num_warps_per_block = 32'd7;
    launch(32'd5);
    step();
    expect_dispatch(0, 0);
    expect_dispatch(1, 1);
    disp_ready = 1'b0;
    step();
    chk("t6_pending", 32'(disp_valid), 32'd1);
    chk("t6_pending_core", 32'(disp_core), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid0", 32'(disp_valid), 32'd0);
    chk("t6_busy0", 32'(busy), 32'd0);
    chk("t6_core0", 32'(disp_core), 32'd0);
    chk("t6_blk0", disp_block_id, 32'd0);
    chk("t6_warps0", disp_num_warps, 32'd0);
    step();
    chk("t6_no_kdone", 32'(kernel_done), 32'd0);
    rst_n = 1'b1;
    disp_ready = 1'b1;
    cfg.num_warps_per_block = 32'd3;
    launch(32'd2);
    step();
    chk("t6_new_warps", disp_num_warps, 32'd3);
    expect_dispatch(0, 0);
    expect_dispatch(1, 1);
    pulse_done(4'b0011);
    chk("t6_kdone", 32'(kernel_done), 32'd1);
    step();
    chk("t6_busy_low", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
